// File: rtl/hilo_unit.sv
// HI/LO architectural registers with MULT/DIV latency model, MT writes and MF reads (HILO_BYPASS_EN: early read of pending result).
// Latency: mult/div commit MUL_LAT/DIV_LAT cycles after issue, done pulses the cycle after; MT writes land at the next edge; reads are combinational.
// Backpressure: while busy, any start/mthi/mtlo/rd request raises stall and is ignored; the requester must re-present it.
module hilo_unit #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic        rt_is_zero,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        rd_hi,
    input  logic        rd_lo,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div0_exc
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The counter holds cycles remaining after the current one, so LAT-1 is loaded.
    localparam logic [3:0] MUL_M1 = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_M1 = 4'(DIV_LAT - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    logic        valid_op;
    logic        is_div;
    logic        issue;
    logic        div0_hit;
    logic        last;
    logic        mt_ok;
    logic        rd_stall;
    logic [31:0] src_hi;
    logic [31:0] src_lo;

    // Signed/unsigned distinction is resolved in the ALU; the bit carries no meaning here.
    logic        unused_sign;
    assign unused_sign = op[1];

    assign valid_op = (op[3:2] == 2'b11);
    assign is_div   = op[0];
    assign issue    = (state == IDLE) && start && valid_op && !(is_div && rt_is_zero);
    assign div0_hit = (state == IDLE) && start && valid_op && is_div && rt_is_zero;
    assign last     = (state == BUSY) && (cnt == 4'd0);
    // A start in the same cycle takes precedence over MT writes.
    assign mt_ok    = (state == IDLE) && !start;

`ifdef HILO_BYPASS_EN
    // The pending result is final in the last busy cycle, so reads may take it directly.
    assign rd_stall = (rd_hi | rd_lo) & ~last;
    assign src_hi   = last ? pend_hi : hi;
    assign src_lo   = last ? pend_lo : lo;
`else
    assign rd_stall = rd_hi | rd_lo;
    assign src_hi   = hi;
    assign src_lo   = lo;
`endif

    assign busy  = (state == BUSY);
    assign stall = busy & (start | mthi | mtlo | rd_stall);
    // No forwarding of same-cycle MT writes: the read sees the committed value.
    assign rdata = rd_hi ? src_hi : (rd_lo ? src_lo : 32'd0);

    // Next-state and counter: issue loads the latency, BUSY counts down to commit.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nx = BUSY;
                    cnt_nx   = is_div ? DIV_M1 : MUL_M1;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // State and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Pending result capture, HI/LO commit or MT write, and the one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_hi  <= 32'd0;
            pend_lo  <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
            div0_exc <= 1'b0;
        end else begin
            if (issue) begin
                pend_hi <= alu_hi;
                pend_lo <= alu_lo;
            end
            if (last) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end else if (mt_ok) begin
                if (mthi) hi <= wdata;
                if (mtlo) lo <= wdata;
            end
            done     <= last;
            div0_exc <= div0_hit;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: directed scenarios plus randomized traffic against a cycle-count reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, before the next rising edge.
// Stall/bypass expectations follow whichever HILO_BYPASS_EN build is compiled.
module tb_hilo_unit;

    localparam int ML = 4;
    localparam int DL = 12;
`ifdef HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic        rt_is_zero;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_hi;
    logic        rd_lo;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div0_exc;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural values plus number of busy cycles still to run.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_rem;
    logic        m_done, m_div0;

    hilo_unit #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .alu_hi(alu_hi), .alu_lo(alu_lo), .rt_is_zero(rt_is_zero),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .rd_hi(rd_hi), .rd_lo(rd_lo), .rdata(rdata),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall),
        .done(done), .div0_exc(div0_exc)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clr();
        start = 0; op = 4'd0; alu_hi = 32'd0; alu_lo = 32'd0; rt_is_zero = 0;
        mthi = 0; mtlo = 0; wdata = 32'd0; rd_hi = 0; rd_lo = 0;
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_rem = 0; m_done = 0; m_div0 = 0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_update();
        logic nd;
        logic nd0;
        nd  = (m_rem == 1);
        nd0 = 1'b0;
        if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start) begin
            if (op[3:2] == 2'b11) begin
                if (op[0] && rt_is_zero) nd0 = 1'b1;
                else begin
                    m_rem = op[0] ? DL : ML;
                    m_phi = alu_hi;
                    m_plo = alu_lo;
                end
            end
        end else begin
            if (mthi) m_hi = wdata;
            if (mtlo) m_lo = wdata;
        end
        m_done = nd;
        m_div0 = nd0;
    endtask

    function automatic logic exp_stall();
        logic rdq;
        rdq = (rd_hi || rd_lo) && !(BYP && m_rem == 1);
        return (m_rem > 0) && (start || mthi || mtlo || rdq);
    endfunction

    function automatic logic [31:0] exp_rdata();
        logic fin;
        fin = BYP && (m_rem == 1);
        if (rd_hi) return fin ? m_phi : m_hi;
        if (rd_lo) return fin ? m_plo : m_lo;
        return 32'd0;
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        clr();
        model_reset();
        #3;
        checks++;
        if ({hi, lo, busy, done, div0_exc, stall} !== 68'd0) begin
            errors++;
            $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b div0=%b stall=%b want all zero",
                     hi, lo, busy, done, div0_exc, stall);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_mult();
        clr();
        start = 1; op = 4'b1110; alu_hi = 32'hFFFFFFFF; alu_lo = 32'hFFFFFFF1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL mult_issue_stall got %b want 0", stall); end
        step();
        clr();
        for (int c = 1; c <= ML; c++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL mult_busy cycle %0d got busy=%b done=%b want 1/0", c, busy, done);
            end
            step();
        end
        rd_lo = 1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
            errors++;
            $display("FAIL mult_commit got busy=%b done=%b hi=%h lo=%h want 0/1/ffffffff/fffffff1", busy, done, hi, lo);
        end
        checks++;
        if (rdata !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_rd_lo got %h want fffffff1", rdata); end
        step();
        clr();
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", done); end
    endtask

    task automatic test_div();
        clr();
        start = 1; op = 4'b1101; alu_hi = 32'd1; alu_lo = 32'd3;
        step();
        clr();
        for (int c = 1; c <= DL; c++) begin
            if (c == 6) rd_hi = 1;
            #1;
            checks++;
            if (busy !== 1'b1 || hi !== m_hi) begin
                errors++; $display("FAIL div_busy cycle %0d got busy=%b hi=%h want 1/%h", c, busy, hi, m_hi);
            end
            if (c == 6) begin
                checks++;
                if (stall !== 1'b1) begin errors++; $display("FAIL div_rd_stall got %b want 1", stall); end
            end
            step();
            rd_hi = 0;
        end
        #1;
        checks++;
        if (hi !== 32'd1 || lo !== 32'd3 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL div_commit got hi=%h lo=%h done=%b busy=%b want 1/3/1/0", hi, lo, done, busy);
        end
        step();
    endtask

    task automatic test_div0();
        clr();
        mthi = 1; wdata = 32'h11;
        step();
        mthi = 0; mtlo = 1; wdata = 32'h22;
        step();
        clr();
        #1;
        checks++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            errors++; $display("FAIL mt_setup got hi=%h lo=%h want 11/22", hi, lo);
        end
        start = 1; op = 4'b1111; rt_is_zero = 1; alu_hi = $urandom; alu_lo = $urandom;
        step();
        clr();
        #1;
        checks++;
        if (div0_exc !== 1'b1 || busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
            errors++; $display("FAIL div0_pulse got div0=%b busy=%b hi=%h lo=%h want 1/0/11/22", div0_exc, busy, hi, lo);
        end
        step();
        #1;
        checks++;
        if (div0_exc !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL div0_one_cycle got div0=%b busy=%b want 0/0", div0_exc, busy);
        end
    endtask

    task automatic test_mt();
        clr();
        mthi = 1; wdata = 32'hDEADBEEF; rd_hi = 1;
        #1;
        checks++;
        if (rdata !== 32'h11) begin errors++; $display("FAIL mt_no_forward got %h want 00000011", rdata); end
        step();
        clr();
        #1;
        checks++;
        if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi_write got %h want deadbeef", hi); end
        start = 1; op = 4'b1100; alu_hi = 32'hA0A0A0A0; alu_lo = 32'hB0B0B0B0;
        mtlo = 1; wdata = 32'h12345678;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL start_mt_stall got %b want 0", stall); end
        step();
        clr();
        #1;
        checks++;
        if (lo !== 32'h22 || busy !== 1'b1) begin
            errors++; $display("FAIL start_wins got lo=%h busy=%b want 00000022/1", lo, busy);
        end
        mtlo = 1; wdata = 32'h0000CAFE;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL mtlo_busy_stall got %b want 1", stall); end
        step();
        clr();
        #1;
        checks++;
        if (lo !== 32'h22) begin errors++; $display("FAIL mtlo_busy_ignored got %h want 00000022", lo); end
        for (int k = 0; k < 20 && busy; k++) step();
        #1;
        checks++;
        if (busy !== 1'b0 || lo !== 32'hB0B0B0B0 || hi !== 32'hA0A0A0A0) begin
            errors++; $display("FAIL mt_mult_commit got busy=%b hi=%h lo=%h want 0/a0a0a0a0/b0b0b0b0", busy, hi, lo);
        end
    endtask

    task automatic test_bypass();
        clr();
        start = 1; op = 4'b1100; alu_hi = 32'h5; alu_lo = 32'h6;
        step();
        clr();
        for (int c = 1; c < ML; c++) step();
        rd_hi = 1;
        #1;
        checks++;
        if (BYP) begin
            if (stall !== 1'b0 || rdata !== 32'h5) begin
                errors++; $display("FAIL bypass_read got stall=%b rdata=%h want 0/00000005", stall, rdata);
            end
        end else begin
            if (stall !== 1'b1 || rdata !== 32'hA0A0A0A0) begin
                errors++; $display("FAIL nobypass_read got stall=%b rdata=%h want 1/a0a0a0a0", stall, rdata);
            end
        end
        step();
        clr();
        #1;
        checks++;
        if (hi !== 32'h5 || lo !== 32'h6 || done !== 1'b1) begin
            errors++; $display("FAIL bypass_commit got hi=%h lo=%h done=%b want 5/6/1", hi, lo, done);
        end
        step();
    endtask

    task automatic test_reset_midbusy();
        clr();
        start = 1; op = 4'b1101; alu_hi = 32'h77; alu_lo = 32'h88;
        step();
        clr();
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_async got hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < DL + 3; c++) begin
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0) begin
                errors++; $display("FAIL reset_abort cycle %0d got done=%b busy=%b hi=%h want 0/0/0", c, done, busy, hi);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [66:0] exp_regs;
        for (int i = 0; i < 400; i++) begin
            start      = ($urandom_range(0, 5) == 0);
            op         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : {2'b11, 2'($urandom)};
            alu_hi     = $urandom;
            alu_lo     = $urandom;
            rt_is_zero = ($urandom_range(0, 3) == 0);
            mthi       = ($urandom_range(0, 4) == 0);
            mtlo       = ($urandom_range(0, 4) == 0);
            wdata      = $urandom;
            rd_hi      = ($urandom_range(0, 2) == 0);
            rd_lo      = ($urandom_range(0, 2) == 0);
            #1;
            exp_regs = {m_hi, m_lo, (m_rem > 0), m_done, m_div0};
            checks++;
            if ({hi, lo, busy, done, div0_exc} !== exp_regs) begin
                errors++;
                $display("FAIL rand_regs cyc %0d got hi=%h lo=%h busy=%b done=%b div0=%b want %h/%h/%b/%b/%b",
                         i, hi, lo, busy, done, div0_exc, m_hi, m_lo, (m_rem > 0), m_done, m_div0);
            end
            checks++;
            if (stall !== exp_stall()) begin
                errors++; $display("FAIL rand_stall cyc %0d got %b want %b", i, stall, exp_stall());
            end
            checks++;
            if (rdata !== exp_rdata()) begin
                errors++; $display("FAIL rand_rdata cyc %0d got %h want %h", i, rdata, exp_rdata());
            end
            step();
        end
        clr();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_mt();
        test_bypass();
        test_reset_midbusy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
